// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
//   Four-digit multiplexed seven-segment driver for a common-anode display.
//   The anodes are scanned round-robin, REFRESH_DIV cycles per digit. Every
//   display output is registered, so anodes and cathodes change on the same
//   edge. In adjustment mode, the digit selected by SEL blinks.
//
//   Optional feature macro: STOPWATCH_DISP_BLINK_EN
//     defined   : the blink counter, blink phase and ADJ/SEL masking are built.
//     undefined : there is no blink logic, ADJ/SEL are ignored, and the ports
//                 are unchanged.
//
// Parameters
//   REFRESH_DIV : clk_c cycles each digit is lit (>= 2)
//   BLINK_DIV   : clk_c cycles per blink half-period (>= 2)
//
// Ports
//   clk_c    in   system clock
//   reset_c  in   asynchronous active-low reset
//   min_tens in   BCD minutes tens   (an[3])
//   min_ones in   BCD minutes ones   (an[2])
//   sec_tens in   BCD seconds tens   (an[1])
//   sec_ones in   BCD seconds ones   (an[0])
//   ADJ      in   adjustment mode active
//   SEL      in   digit under adjustment (00 sec_ones .. 11 min_tens)
//   seg      out  cathodes, active-low, bit order gfedcba
//   an       out  anodes, active-low
//   dp       out  decimal point / colon, active-low, lit in the min_ones slot
// -----------------------------------------------------------------------------
module stopwatch_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          ref_wrap;
  logic          dark;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  // Scan timing
  assign ref_wrap = (ref_cnt_q == RW'(REFRESH_DIV - 1));

  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    idx_d     = idx_q;
    if (ref_wrap) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

`ifdef STOPWATCH_DISP_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // The counter is held at zero outside ADJ, so each entry into adjustment
  // starts with a full visible half-period.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_ph_d  = blink_ph_q;
    if (!ADJ) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge clk_c or negedge reset_c) begin
    if (!reset_c) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // ADJ is used live, so leaving adjustment relights the digit on the next edge.
  assign dark = ADJ & blink_ph_q & (idx_q == SEL);
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;
  logic unused_ctrl;
  assign unused_ctrl = ^{ADJ, SEL};
  assign dark        = 1'b0;
`endif

  // Output decode. It uses the current idx, so an output follows an idx
  // change one cycle later.
  always_comb begin
    case (idx_q)
      2'd0:    digit = sec_ones;
      2'd1:    digit = sec_tens;
      2'd2:    digit = min_ones;
      default: digit = min_tens;
    endcase
    seg_d        = decode(digit);
    an_d         = 4'b1111;
    an_d[idx_q]  = dark;
    dp_d         = (idx_q != 2'd2);
  end

  always_ff @(posedge clk_c or negedge reset_c) begin
    if (!reset_c) begin
      ref_cnt_q <= '0;
      idx_q     <= 2'd0;
      seg_q     <= 7'b1111111;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;
  localparam int RD = 4;
  localparam int BD = 8;

  logic       clk_c = 1'b0;
  logic       reset_c;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       ADJ;
  logic [1:0] SEL;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_ref, m_idx, m_bc;
  bit m_ph;
  bit blink_built;

  logic [11:0] sb_q[$];  // {seg, an, dp}

  stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk_c(clk_c), .reset_c(reset_c),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .ADJ(ADJ), .SEL(SEL),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk_c = ~clk_c;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed={seg,an,dp}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ref = 0; m_idx = 0; m_bc = 0; m_ph = 1'b0;
  endtask

  // Push the expected output for the coming edge, clock it, then pop and compare.
  task automatic tick(input string tag);
    logic [3:0]  d;
    logic [3:0]  ea;
    logic [11:0] e;
    case (m_idx)
      0: d = sec_ones;
      1: d = sec_tens;
      2: d = min_ones;
      default: d = min_tens;
    endcase
    ea = 4'b1111;
    ea[m_idx] = 1'b0;
    if (blink_built && ADJ && m_ph && (m_idx == int'(SEL))) ea[m_idx] = 1'b1;
    sb_q.push_back({enc(d), ea, (m_idx != 2)});
    @(posedge clk_c);
    if (m_ref == RD - 1) begin m_ref = 0; m_idx = (m_idx + 1) % 4; end
    else m_ref++;
    if (!ADJ) begin m_bc = 0; m_ph = 1'b0; end
    else if (m_bc == BD - 1) begin m_bc = 0; m_ph = ~m_ph; end
    else m_bc++;
    #1;
    e = sb_q.pop_front();
    chk(tag, {seg, an, dp}, e);
  endtask

  initial begin
`ifdef STOPWATCH_DISP_BLINK_EN
    blink_built = 1'b1;
`else
    blink_built = 1'b0;
`endif
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    ADJ = 1'b0; SEL = 2'b00;
    model_reset();

    // Reset state
    reset_c = 1'b1;
    #2 reset_c = 1'b0;
    #1 chk("reset_async", {seg, an, dp}, {7'b1111111, 4'b1111, 1'b1});
    repeat (2) @(posedge clk_c);
    #1 chk("reset_held", {seg, an, dp}, {7'b1111111, 4'b1111, 1'b1});

    // Release; the first output is sec_ones in slot 0
    reset_c = 1'b1;
    tick("first_after_reset");
    chk("first_digit", {seg, an, dp}, {7'b0011001, 4'b1110, 1'b1});
    for (int i = 1; i < 16; i++) begin
      tick("scan_frame");
      if (i == 8) chk("colon_slot", {seg, an, dp}, {7'b0100100, 4'b1011, 1'b0});
      if (i == 12) chk("min_tens_slot", {seg, an, dp}, {7'b1111001, 4'b0111, 1'b1});
    end

    // Asynchronous reset mid-slot at idx 2
    for (int i = 0; i < 16 && !(m_idx == 2 && m_ref == 1); i++) tick("seek_idx2");
    chk("at_idx2", {1'b0, an, dp}, {1'b0, 4'b1011, 1'b0});
    #2 reset_c = 1'b0;
    #1 chk("reset_midslot", {seg, an, dp}, {7'b1111111, 4'b1111, 1'b1});
    @(posedge clk_c);
    #1 reset_c = 1'b1;
    model_reset();
    tick("restart");
    chk("restart_slot0", {seg, an, dp}, {7'b0011001, 4'b1110, 1'b1});
    repeat (15) tick("restart_frame");

    // Every sec_ones value, including non-BCD dash
    for (int v = 0; v < 16; v++) begin
      sec_ones = v[3:0];
      repeat (16) tick("decode_sweep");
    end
    sec_ones = 4'hC;
    for (int i = 0; i < 16; i++) begin
      tick("dash");
      if (an == 4'b1110) chk("dash_seg", {seg, 5'b0}, {7'b0111111, 5'b0});
    end

    // Mid-slot live change of a digit
    min_tens = 4'd7; min_ones = 4'd5; sec_tens = 4'd9; sec_ones = 4'd0;
    repeat (5) tick("live_a");
    sec_tens = 4'd6;
    repeat (11) tick("live_b");

    // Blink SEL=10; re-enter at a slot boundary
    SEL = 2'b10;
    ADJ = 1'b1;
    repeat (64) tick("blink_sel2");

    // Drop ADJ mid-dark phase on slot 2
    for (int i = 0; i < 64 && !(m_ph && m_idx == 2 && m_ref == 1); i++) tick("seek_dark");
    if (blink_built) chk("dark_digit", {5'b0, an, dp}, {5'b0, 4'b1111, 1'b0});
    ADJ = 1'b0;
    tick("adj_drop");
    chk("relit", {5'b0, an, dp}, {5'b0, 4'b1011, 1'b0});
    repeat (5) tick("adj_off");
    ADJ = 1'b1;
    repeat (40) tick("adj_reenter");

    // SEL=00 blinks sec_ones; with no blink built, the scan matches ADJ=0
    ADJ = 1'b0;
    repeat (3) tick("pre_sel0");
    SEL = 2'b00;
    ADJ = 1'b1;
    repeat (48) tick("sel0");

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
